exu_lsu: RTL and testbench

Load/store execution unit in the EXU, directly downstream of the single-cycle ALU. The ALU computes the effective address (rs1 + imm) and presents it on its LSU-result output; this block latches that address along with the store data and access type. It runs one data-bus transaction through a request/grant/rvalid handshake, then produces a sign- or zero-extended load result for register writeback. It also flags misaligned accesses instead of issuing them.

---
 rtl/exu_lsu_if.sv | 47 ++++
 rtl/exu_lsu.sv | 111 +++++++++++
 tb/tb_exu_lsu.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/exu_lsu_if.sv
// Dispatch-side and data-bus-side signals of the load/store unit.
// The slave modport is the LSU's view; master is the surrounding EXU/bus.
interface exu_lsu_if #(
    parameter int XLEN   = 32,
    parameter int RFIDXW = 5
) ();
    logic              i_lsu_valid;
    logic              o_lsu_ready;
    logic [XLEN-1:0]   i_lsu_addr;
    logic [XLEN-1:0]   i_lsu_wdata;
    logic              i_lsu_load;
    logic              i_lsu_store;
    logic [1:0]        i_lsu_size;
    logic              i_lsu_unsigned;
    logic [RFIDXW-1:0] i_lsu_rdidx;

    logic              o_bus_req;
    logic              o_bus_we;
    logic [XLEN-1:0]   o_bus_addr;
    logic [XLEN-1:0]   o_bus_wdata;
    logic [3:0]        o_bus_wmask;
    logic              i_bus_gnt;
    logic              i_bus_rvalid;
    logic [XLEN-1:0]   i_bus_rdata;

    logic              o_lsu_rdwen;
    logic [RFIDXW-1:0] o_lsu_rdidx;
    logic [XLEN-1:0]   o_lsu_rdwdata;
    logic              o_lsu_misalign;
    logic              o_lsu_busy;

    modport slave (
        input  i_lsu_valid, i_lsu_addr, i_lsu_wdata, i_lsu_load, i_lsu_store,
               i_lsu_size, i_lsu_unsigned, i_lsu_rdidx,
               i_bus_gnt, i_bus_rvalid, i_bus_rdata,
        output o_lsu_ready, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wmask,
               o_lsu_rdwen, o_lsu_rdidx, o_lsu_rdwdata, o_lsu_misalign, o_lsu_busy
    );

    modport master (
        output i_lsu_valid, i_lsu_addr, i_lsu_wdata, i_lsu_load, i_lsu_store,
               i_lsu_size, i_lsu_unsigned, i_lsu_rdidx,
               i_bus_gnt, i_bus_rvalid, i_bus_rdata,
        input  o_lsu_ready, o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wmask,
               o_lsu_rdwen, o_lsu_rdidx, o_lsu_rdwdata, o_lsu_misalign, o_lsu_busy
    );
endinterface

// File: rtl/exu_lsu.sv
// Load/store unit: latches an ALU-computed address, runs one req/gnt/rvalid
// bus transaction and returns an extended load result for writeback.
module exu_lsu #(
    parameter int XLEN   = 32,
    parameter int RFIDXW = 5
) (
    input  logic      i_clk,
    input  logic      i_rstn,
    exu_lsu_if.slave  io
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [XLEN-1:0]   r_addr, r_wdata, r_wb_data;
    logic [3:0]        r_wmask;
    logic              r_we, r_uns, r_rdwen, r_misalign;
    logic [1:0]        r_size;
    logic [RFIDXW-1:0] r_rdidx, r_wb_idx;
    logic              w_accept, w_misal, w_store;

    function automatic logic [XLEN-1:0] lane_wdata(input logic [XLEN-1:0] d, input logic [1:0] sz);
        case (sz)
            2'b00:   return {(XLEN/8){d[7:0]}};
            2'b01:   return {(XLEN/16){d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Shifting by the byte offset lines the addressed byte/half up at bit 0.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rd, input logic [1:0] lo,
                                                 input logic [1:0] sz, input logic uns);
        logic [XLEN-1:0] sh;
        sh = rd >> {lo, 3'b000};
        case (sz)
            2'b00:   return {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
            2'b01:   return {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    assign w_store  = io.i_lsu_store;
    assign w_accept = io.i_lsu_valid & (r_state == IDLE) & (io.i_lsu_load | io.i_lsu_store);
    assign w_misal  = ((io.i_lsu_size == 2'b01) & io.i_lsu_addr[0]) |
                      (io.i_lsu_size[1] & (io.i_lsu_addr[1:0] != 2'b00));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_misal) w_state_nxt = REQ;
            REQ:     if (io.i_bus_gnt) w_state_nxt = r_we ? IDLE : WAIT;
            WAIT:    if (io.i_bus_rvalid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= '0;
            r_rdidx    <= '0;
            r_rdwen    <= 1'b0;
            r_wb_idx   <= '0;
            r_wb_data  <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_misalign <= w_accept & w_misal;
            r_rdwen    <= 1'b0;
            if (w_accept) begin
                r_addr  <= io.i_lsu_addr;
                r_we    <= w_store;
                r_wdata <= lane_wdata(io.i_lsu_wdata, io.i_lsu_size);
                r_wmask <= w_store ? lane_mask(io.i_lsu_size, io.i_lsu_addr[1:0]) : 4'b0000;
                r_size  <= io.i_lsu_size;
                r_uns   <= io.i_lsu_unsigned;
                r_rdidx <= io.i_lsu_rdidx;
            end
            // x0 loads complete on the bus but leave the writeback registers untouched.
            if (r_state == WAIT && io.i_bus_rvalid && r_rdidx != '0) begin
                r_rdwen   <= 1'b1;
                r_wb_idx  <= r_rdidx;
                r_wb_data <= load_ext(io.i_bus_rdata, r_addr[1:0], r_size, r_uns);
            end
        end
    end

    assign io.o_lsu_ready    = (r_state == IDLE);
    assign io.o_lsu_busy     = (r_state != IDLE);
    assign io.o_bus_req      = (r_state == REQ);
    assign io.o_bus_we       = r_we;
    assign io.o_bus_addr     = r_addr;
    assign io.o_bus_wdata    = r_wdata;
    assign io.o_bus_wmask    = r_wmask;
    assign io.o_lsu_rdwen    = r_rdwen;
    assign io.o_lsu_rdidx    = r_wb_idx;
    assign io.o_lsu_rdwdata  = r_wb_data;
    assign io.o_lsu_misalign = r_misalign;
endmodule

// File: tb/tb_exu_lsu.sv
// Directed bench for exu_lsu: loads, stores, misalignment, stalls and reset.
module tb_exu_lsu;
    localparam int XLEN   = 32;
    localparam int RFIDXW = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    exu_lsu_if #(.XLEN(XLEN), .RFIDXW(RFIDXW)) ifc ();

    exu_lsu #(.XLEN(XLEN), .RFIDXW(RFIDXW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .io     (ifc)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifc.i_lsu_valid    = 1'b0;
        ifc.i_lsu_addr     = '0;
        ifc.i_lsu_wdata    = '0;
        ifc.i_lsu_load     = 1'b0;
        ifc.i_lsu_store    = 1'b0;
        ifc.i_lsu_size     = 2'b00;
        ifc.i_lsu_unsigned = 1'b0;
        ifc.i_lsu_rdidx    = '0;
        ifc.i_bus_gnt      = 1'b0;
        ifc.i_bus_rvalid   = 1'b0;
        ifc.i_bus_rdata    = '0;
    endtask

    task automatic offer(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        ifc.i_lsu_valid    = 1'b1;
        ifc.i_lsu_load     = ld;
        ifc.i_lsu_store    = st;
        ifc.i_lsu_size     = sz;
        ifc.i_lsu_unsigned = uns;
        ifc.i_lsu_addr     = a;
        ifc.i_lsu_wdata    = wd;
        ifc.i_lsu_rdidx    = rd;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        cyc(); cyc();
        if (ifc.o_lsu_ready !== 1'b1) begin $display("FAIL reset_ready got %b exp 1", ifc.o_lsu_ready); n_fail++; end n_tests++;
        if (ifc.o_lsu_busy !== 1'b0) begin $display("FAIL reset_busy got %b exp 0", ifc.o_lsu_busy); n_fail++; end n_tests++;
        if (ifc.o_bus_req !== 1'b0) begin $display("FAIL reset_req got %b exp 0", ifc.o_bus_req); n_fail++; end n_tests++;
        if (ifc.o_bus_we !== 1'b0) begin $display("FAIL reset_we got %b exp 0", ifc.o_bus_we); n_fail++; end n_tests++;
        if (ifc.o_bus_addr !== 32'h0) begin $display("FAIL reset_addr got %h exp 0", ifc.o_bus_addr); n_fail++; end n_tests++;
        if (ifc.o_bus_wdata !== 32'h0) begin $display("FAIL reset_wdata got %h exp 0", ifc.o_bus_wdata); n_fail++; end n_tests++;
        if (ifc.o_bus_wmask !== 4'h0) begin $display("FAIL reset_wmask got %b exp 0000", ifc.o_bus_wmask); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdwen !== 1'b0) begin $display("FAIL reset_rdwen got %b exp 0", ifc.o_lsu_rdwen); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdidx !== 5'd0) begin $display("FAIL reset_rdidx got %0d exp 0", ifc.o_lsu_rdidx); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdwdata !== 32'h0) begin $display("FAIL reset_rdwdata got %h exp 0", ifc.o_lsu_rdwdata); n_fail++; end n_tests++;
        if (ifc.o_lsu_misalign !== 1'b0) begin $display("FAIL reset_misalign got %b exp 0", ifc.o_lsu_misalign); n_fail++; end n_tests++;
        rstn = 1'b1;
    endtask

    task automatic test_lw();
        cyc(); offer(1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 5'd5);
        cyc(); ifc.i_lsu_valid = 1'b0; ifc.i_bus_gnt = 1'b1;
        if (ifc.o_bus_req !== 1'b1) begin $display("FAIL lw_req got %b exp 1", ifc.o_bus_req); n_fail++; end n_tests++;
        if (ifc.o_bus_we !== 1'b0) begin $display("FAIL lw_we got %b exp 0", ifc.o_bus_we); n_fail++; end n_tests++;
        if (ifc.o_bus_addr !== 32'h1000) begin $display("FAIL lw_addr got %h exp 00001000", ifc.o_bus_addr); n_fail++; end n_tests++;
        if (ifc.o_bus_wmask !== 4'b0000) begin $display("FAIL lw_wmask got %b exp 0000", ifc.o_bus_wmask); n_fail++; end n_tests++;
        if (ifc.o_lsu_ready !== 1'b0) begin $display("FAIL lw_ready_c1 got %b exp 0", ifc.o_lsu_ready); n_fail++; end n_tests++;
        cyc(); ifc.i_bus_gnt = 1'b0; ifc.i_bus_rvalid = 1'b1; ifc.i_bus_rdata = 32'hDEADBEEF;
        if (ifc.o_bus_req !== 1'b0) begin $display("FAIL lw_req_wait got %b exp 0", ifc.o_bus_req); n_fail++; end n_tests++;
        if (ifc.o_lsu_busy !== 1'b1) begin $display("FAIL lw_busy_wait got %b exp 1", ifc.o_lsu_busy); n_fail++; end n_tests++;
        cyc(); ifc.i_bus_rvalid = 1'b0;
        if (ifc.o_lsu_rdwen !== 1'b1) begin $display("FAIL lw_rdwen got %b exp 1", ifc.o_lsu_rdwen); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdidx !== 5'd5) begin $display("FAIL lw_rdidx got %0d exp 5", ifc.o_lsu_rdidx); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdwdata !== 32'hDEADBEEF) begin $display("FAIL lw_rdwdata got %h exp deadbeef", ifc.o_lsu_rdwdata); n_fail++; end n_tests++;
        if (ifc.o_lsu_ready !== 1'b1) begin $display("FAIL lw_ready_c3 got %b exp 1", ifc.o_lsu_ready); n_fail++; end n_tests++;
        cyc();
        if (ifc.o_lsu_rdwen !== 1'b0) begin $display("FAIL lw_rdwen_pulse got %b exp 0", ifc.o_lsu_rdwen); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdwdata !== 32'hDEADBEEF) begin $display("FAIL lw_rdwdata_hold got %h exp deadbeef", ifc.o_lsu_rdwdata); n_fail++; end n_tests++;
    endtask

    task automatic do_load(input string nm, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] rdata, input logic [31:0] exp);
        cyc(); offer(1'b1, 1'b0, sz, uns, a, 32'h0, 5'd9);
        cyc(); ifc.i_lsu_valid = 1'b0; ifc.i_bus_gnt = 1'b1;
        cyc(); ifc.i_bus_gnt = 1'b0; ifc.i_bus_rvalid = 1'b1; ifc.i_bus_rdata = rdata;
        cyc(); ifc.i_bus_rvalid = 1'b0;
        if (ifc.o_lsu_rdwen !== 1'b1) begin $display("FAIL %s_rdwen got %b exp 1", nm, ifc.o_lsu_rdwen); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdwdata !== exp) begin $display("FAIL %s_data got %h exp %h", nm, ifc.o_lsu_rdwdata, exp); n_fail++; end n_tests++;
    endtask

    task automatic test_load_ext();
        do_load("lb",   2'b00, 1'b0, 32'h1003, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("lbu",  2'b00, 1'b1, 32'h1003, 32'h80FF_0000, 32'h0000_0080);
        do_load("lh",   2'b01, 1'b0, 32'h1002, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lhu",  2'b01, 1'b1, 32'h1002, 32'h8001_0000, 32'h0000_8001);
        do_load("lb0",  2'b00, 1'b0, 32'h1000, 32'h1234_567F, 32'h0000_007F);
        do_load("lb1",  2'b00, 1'b0, 32'h1001, 32'h0000_9C00, 32'hFFFF_FF9C);
        do_load("lh0",  2'b01, 1'b0, 32'h1000, 32'hFFFF_7FFE, 32'h0000_7FFE);
        do_load("lw11", 2'b11, 1'b1, 32'h1004, 32'h8765_4321, 32'h8765_4321);
    endtask

    task automatic do_store(input string nm, input logic ld, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_wd, input logic [3:0] exp_m,
                            input int stall);
        cyc(); offer(ld, 1'b1, sz, 1'b0, a, wd, 5'd3);
        for (int i = 0; i <= stall; i++) begin
            cyc(); ifc.i_lsu_valid = 1'b0; ifc.i_bus_gnt = (i == stall);
            if (ifc.o_bus_req !== 1'b1) begin $display("FAIL %s_req[%0d] got %b exp 1", nm, i, ifc.o_bus_req); n_fail++; end n_tests++;
            if (ifc.o_bus_we !== 1'b1) begin $display("FAIL %s_we[%0d] got %b exp 1", nm, i, ifc.o_bus_we); n_fail++; end n_tests++;
            if (ifc.o_bus_addr !== a) begin $display("FAIL %s_addr[%0d] got %h exp %h", nm, i, ifc.o_bus_addr, a); n_fail++; end n_tests++;
            if (ifc.o_bus_wdata !== exp_wd) begin $display("FAIL %s_wdata[%0d] got %h exp %h", nm, i, ifc.o_bus_wdata, exp_wd); n_fail++; end n_tests++;
            if (ifc.o_bus_wmask !== exp_m) begin $display("FAIL %s_wmask[%0d] got %b exp %b", nm, i, ifc.o_bus_wmask, exp_m); n_fail++; end n_tests++;
            if (ifc.o_lsu_ready !== 1'b0) begin $display("FAIL %s_ready[%0d] got %b exp 0", nm, i, ifc.o_lsu_ready); n_fail++; end n_tests++;
        end
        cyc(); ifc.i_bus_gnt = 1'b0;
        if (ifc.o_lsu_ready !== 1'b1) begin $display("FAIL %s_ready_after got %b exp 1", nm, ifc.o_lsu_ready); n_fail++; end n_tests++;
        if (ifc.o_bus_req !== 1'b0) begin $display("FAIL %s_req_after got %b exp 0", nm, ifc.o_bus_req); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdwen !== 1'b0) begin $display("FAIL %s_rdwen got %b exp 0", nm, ifc.o_lsu_rdwen); n_fail++; end n_tests++;
    endtask

    task automatic test_stores();
        do_store("sb",    1'b0, 2'b00, 32'h2001, 32'h1234_5678, 32'h7878_7878, 4'b0010, 0);
        do_store("sh",    1'b0, 2'b01, 32'h2002, 32'h1234_5678, 32'h5678_5678, 4'b1100, 0);
        do_store("sw",    1'b0, 2'b10, 32'h2000, 32'h1234_5678, 32'h1234_5678, 4'b1111, 0);
        do_store("sb3",   1'b0, 2'b00, 32'h2003, 32'hAABB_CCDD, 32'hDDDD_DDDD, 4'b1000, 0);
        do_store("sh0",   1'b0, 2'b01, 32'h2000, 32'hAABB_CCDD, 32'hCCDD_CCDD, 4'b0011, 0);
        do_store("stall", 1'b0, 2'b10, 32'h2008, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 5);
        do_store("ldst",  1'b1, 2'b10, 32'h200C, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 4'b1111, 0);
    endtask

    task automatic do_misalign(input string nm, input logic ld, input logic st, input logic [1:0] sz,
                               input logic [31:0] a);
        cyc(); offer(ld, st, sz, 1'b0, a, 32'h5555_AAAA, 5'd4);
        cyc(); ifc.i_lsu_valid = 1'b0; ifc.i_bus_gnt = 1'b1; ifc.i_bus_rvalid = 1'b1;
        if (ifc.o_lsu_misalign !== 1'b1) begin $display("FAIL %s_pulse got %b exp 1", nm, ifc.o_lsu_misalign); n_fail++; end n_tests++;
        if (ifc.o_lsu_ready !== 1'b1) begin $display("FAIL %s_ready got %b exp 1", nm, ifc.o_lsu_ready); n_fail++; end n_tests++;
        if (ifc.o_bus_req !== 1'b0) begin $display("FAIL %s_req got %b exp 0", nm, ifc.o_bus_req); n_fail++; end n_tests++;
        cyc(); ifc.i_bus_gnt = 1'b0; ifc.i_bus_rvalid = 1'b0;
        if (ifc.o_lsu_misalign !== 1'b0) begin $display("FAIL %s_pulse_end got %b exp 0", nm, ifc.o_lsu_misalign); n_fail++; end n_tests++;
        if (ifc.o_bus_req !== 1'b0) begin $display("FAIL %s_req2 got %b exp 0", nm, ifc.o_bus_req); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdwen !== 1'b0) begin $display("FAIL %s_rdwen got %b exp 0", nm, ifc.o_lsu_rdwen); n_fail++; end n_tests++;
        if (ifc.o_lsu_busy !== 1'b0) begin $display("FAIL %s_busy got %b exp 0", nm, ifc.o_lsu_busy); n_fail++; end n_tests++;
    endtask

    task automatic test_misalign();
        do_misalign("mis_lw", 1'b1, 1'b0, 2'b10, 32'h1001);
        do_misalign("mis_sh", 1'b0, 1'b1, 2'b01, 32'h1003);
        do_misalign("mis_lh", 1'b1, 1'b0, 2'b01, 32'h1005);
        do_misalign("mis_w3", 1'b0, 1'b1, 2'b11, 32'h1002);
        // valid with neither kind is dropped without any effect
        cyc(); offer(1'b0, 1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 5'd2);
        cyc(); ifc.i_lsu_valid = 1'b0;
        if (ifc.o_lsu_busy !== 1'b0) begin $display("FAIL nokind_busy got %b exp 0", ifc.o_lsu_busy); n_fail++; end n_tests++;
        if (ifc.o_bus_req !== 1'b0) begin $display("FAIL nokind_req got %b exp 0", ifc.o_bus_req); n_fail++; end n_tests++;
    endtask

    task automatic test_x0_and_early_rvalid();
        cyc(); offer(1'b1, 1'b0, 2'b10, 1'b0, 32'h1100, 32'h0, 5'd0);
        cyc(); ifc.i_lsu_valid = 1'b0; ifc.i_bus_gnt = 1'b1;
        cyc(); ifc.i_bus_gnt = 1'b0; ifc.i_bus_rvalid = 1'b1; ifc.i_bus_rdata = 32'h1357_9BDF;
        cyc(); ifc.i_bus_rvalid = 1'b0;
        if (ifc.o_lsu_rdwen !== 1'b0) begin $display("FAIL x0_rdwen got %b exp 0", ifc.o_lsu_rdwen); n_fail++; end n_tests++;
        if (ifc.o_lsu_ready !== 1'b1) begin $display("FAIL x0_ready got %b exp 1", ifc.o_lsu_ready); n_fail++; end n_tests++;

        cyc(); offer(1'b1, 1'b0, 2'b10, 1'b0, 32'h1104, 32'h0, 5'd7);
        cyc(); ifc.i_lsu_valid = 1'b0; ifc.i_bus_gnt = 1'b1; ifc.i_bus_rvalid = 1'b1; ifc.i_bus_rdata = 32'h1111_1111;
        cyc(); ifc.i_bus_gnt = 1'b0; ifc.i_bus_rvalid = 1'b0;
        if (ifc.o_lsu_rdwen !== 1'b0) begin $display("FAIL early_rv_rdwen got %b exp 0", ifc.o_lsu_rdwen); n_fail++; end n_tests++;
        if (ifc.o_lsu_busy !== 1'b1) begin $display("FAIL early_rv_busy got %b exp 1", ifc.o_lsu_busy); n_fail++; end n_tests++;
        cyc(); ifc.i_bus_rvalid = 1'b1; ifc.i_bus_rdata = 32'h2222_2222;
        if (ifc.o_lsu_rdwen !== 1'b0) begin $display("FAIL early_rv_idle got %b exp 0", ifc.o_lsu_rdwen); n_fail++; end n_tests++;
        cyc(); ifc.i_bus_rvalid = 1'b0;
        if (ifc.o_lsu_rdwen !== 1'b1) begin $display("FAIL late_rv_rdwen got %b exp 1", ifc.o_lsu_rdwen); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdidx !== 5'd7) begin $display("FAIL late_rv_rdidx got %0d exp 7", ifc.o_lsu_rdidx); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdwdata !== 32'h2222_2222) begin $display("FAIL late_rv_data got %h exp 22222222", ifc.o_lsu_rdwdata); n_fail++; end n_tests++;
    endtask

    task automatic test_back_to_back();
        cyc(); offer(1'b1, 1'b0, 2'b00, 1'b1, 32'h1201, 32'h0, 5'd12);
        cyc(); ifc.i_lsu_valid = 1'b0; ifc.i_bus_gnt = 1'b1;
        cyc(); ifc.i_bus_gnt = 1'b0; ifc.i_bus_rvalid = 1'b1; ifc.i_bus_rdata = 32'h0000_A500;
        cyc(); ifc.i_bus_rvalid = 1'b0;
        if (ifc.o_lsu_rdwen !== 1'b1) begin $display("FAIL b2b_rdwen got %b exp 1", ifc.o_lsu_rdwen); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdwdata !== 32'h0000_00A5) begin $display("FAIL b2b_data got %h exp 000000a5", ifc.o_lsu_rdwdata); n_fail++; end n_tests++;
        if (ifc.o_lsu_ready !== 1'b1) begin $display("FAIL b2b_ready got %b exp 1", ifc.o_lsu_ready); n_fail++; end n_tests++;
        offer(1'b0, 1'b1, 2'b00, 1'b0, 32'h2202, 32'h0000_00C3, 5'd0);
        cyc(); ifc.i_lsu_valid = 1'b0; ifc.i_bus_gnt = 1'b1;
        if (ifc.o_bus_req !== 1'b1) begin $display("FAIL b2b_req got %b exp 1", ifc.o_bus_req); n_fail++; end n_tests++;
        if (ifc.o_bus_wmask !== 4'b0100) begin $display("FAIL b2b_wmask got %b exp 0100", ifc.o_bus_wmask); n_fail++; end n_tests++;
        if (ifc.o_bus_wdata !== 32'hC3C3_C3C3) begin $display("FAIL b2b_wdata got %h exp c3c3c3c3", ifc.o_bus_wdata); n_fail++; end n_tests++;
        cyc(); ifc.i_bus_gnt = 1'b0;
        if (ifc.o_lsu_ready !== 1'b1) begin $display("FAIL b2b_done got %b exp 1", ifc.o_lsu_ready); n_fail++; end n_tests++;
    endtask

    task automatic test_reset_mid();
        cyc(); offer(1'b1, 1'b0, 2'b10, 1'b0, 32'h1300, 32'h0, 5'd6);
        cyc(); ifc.i_lsu_valid = 1'b0; ifc.i_bus_gnt = 1'b1;
        cyc(); ifc.i_bus_gnt = 1'b0; rstn = 1'b0;
        if (ifc.o_lsu_busy !== 1'b1) begin $display("FAIL rmid_busy_before got %b exp 1", ifc.o_lsu_busy); n_fail++; end n_tests++;
        cyc(); rstn = 1'b1;
        if (ifc.o_bus_req !== 1'b0) begin $display("FAIL rmid_req got %b exp 0", ifc.o_bus_req); n_fail++; end n_tests++;
        if (ifc.o_lsu_ready !== 1'b1) begin $display("FAIL rmid_ready got %b exp 1", ifc.o_lsu_ready); n_fail++; end n_tests++;
        if (ifc.o_lsu_busy !== 1'b0) begin $display("FAIL rmid_busy got %b exp 0", ifc.o_lsu_busy); n_fail++; end n_tests++;
        if (ifc.o_bus_addr !== 32'h0) begin $display("FAIL rmid_addr got %h exp 0", ifc.o_bus_addr); n_fail++; end n_tests++;
        ifc.i_bus_rvalid = 1'b1; ifc.i_bus_rdata = 32'hAAAA_5555;
        cyc(); ifc.i_bus_rvalid = 1'b0;
        if (ifc.o_lsu_rdwen !== 1'b0) begin $display("FAIL rmid_rdwen got %b exp 0", ifc.o_lsu_rdwen); n_fail++; end n_tests++;
        if (ifc.o_lsu_rdwdata !== 32'h0) begin $display("FAIL rmid_rdwdata got %h exp 0", ifc.o_lsu_rdwdata); n_fail++; end n_tests++;
        if (ifc.o_lsu_busy !== 1'b0) begin $display("FAIL rmid_busy2 got %b exp 0", ifc.o_lsu_busy); n_fail++; end n_tests++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_stores();
        test_misalign();
        test_x0_and_early_rvalid();
        test_back_to_back();
        test_reset_mid();
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
